// File: rtl/muxn_arb_if.sv
// Handshake bundle for muxn_arb: N request channels in, one registered word out.
// slave = the arbiter side, master = the side that drives requests and consumes output.
interface muxn_arb_if #(
  parameter int WIDTH = 64,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
);
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [N*WIDTH-1:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_sel;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/muxn_arb.sv
// N-input registered selector with valid/ready flow control.
// MUXN_ARB_RR_EN defined   : round-robin arbitration with a rotating pointer.
// MUXN_ARB_RR_EN undefined : fixed priority, lowest index wins, no pointer state.
// One output register; it may drain and refill in the same cycle.
module muxn_arb #(
  parameter int WIDTH = 64,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input logic       clk,
  input logic       reset,
  muxn_arb_if.slave bus
);

  logic            load;
  logic            found;
  logic [SELW-1:0] gsel;
  logic [N-1:0]    rdy;
  logic            xfer_in;
  logic [SELW-1:0] base;
  int              idx;

`ifdef MUXN_ARB_RR_EN
  logic [SELW-1:0] ptr;
  assign base = ptr;
`else
  assign base = '0;
`endif

  // Register is free when empty or being drained this cycle; nothing is
  // granted while reset is held so in_ready stays low during reset.
  assign load = !reset && (!bus.out_valid || bus.out_ready);

  // Search channels base, base+1, ..., wrapping explicitly so any N works.
  always_comb begin
    found = 1'b0;
    gsel  = '0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(base) + k;
      if (idx >= N) idx = idx - N;
      if (!found && bus.in_valid[idx]) begin
        found = 1'b1;
        gsel  = SELW'(idx);
      end
    end
  end

  // One-hot accept for the winning channel, only when the register can load.
  always_comb begin
    rdy = '0;
    for (int i = 0; i < N; i++)
      rdy[i] = load && found && (gsel == SELW'(i));
  end

  assign bus.in_ready = rdy;
  assign xfer_in      = load && found;

  // Output register: refill on an input transfer, empty on a bare drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sel   <= '0;
    end else if (xfer_in) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= bus.in_data[int'(gsel)*WIDTH +: WIDTH];
      bus.out_sel   <= gsel;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

`ifdef MUXN_ARB_RR_EN
  // Pointer moves to the channel after the winner so it gets lowest priority next.
  always_ff @(posedge clk) begin
    if (reset)
      ptr <= '0;
    else if (xfer_in)
      ptr <= (gsel == SELW'(N-1)) ? '0 : gsel + 1'b1;
  end
`endif

endmodule

// File: tb/tb_muxn_arb.sv
// Directed bench for muxn_arb: an N=4 instance for the main flow and an N=3
// instance for pointer wrap. Expected values follow the configured arbitration.
module tb_muxn_arb;

`ifdef MUXN_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muxn_arb_if #(.WIDTH(64), .N(4)) bus_a ();
  muxn_arb_if #(.WIDTH(64), .N(3)) bus_b ();

  muxn_arb #(.WIDTH(64), .N(4)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  muxn_arb #(.WIDTH(64), .N(3)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] er;
    int         es;
    int         hold;

    reset          = 1'b1;
    bus_a.in_valid = 4'b1111;
    bus_a.in_data  = '0;
    bus_a.out_ready = 1'b0;
    bus_b.in_valid = '0;
    bus_b.in_data  = '0;
    bus_b.out_ready = 1'b0;

    // reset state, with requests present to show no grant during reset
    tick(); tick();
    @(negedge clk);
    chk("rst_valid", 64'(bus_a.out_valid), 64'd0);
    chk("rst_data",  bus_a.out_data, 64'd0);
    chk("rst_sel",   64'(bus_a.out_sel), 64'd0);
    chk("rst_ready", 64'(bus_a.in_ready), 64'd0);

    // single source on channel 2
    tick();
    reset = 1'b0;
    bus_a.in_valid = 4'b0100;
    bus_a.in_data[2*64 +: 64] = 64'hA5;
    bus_a.out_ready = 1'b1;
    @(negedge clk);
    chk("single_ready", 64'(bus_a.in_ready), 64'b0100);
    tick();
    bus_a.in_valid = 4'b0000;
    @(negedge clk);
    chk("single_valid", 64'(bus_a.out_valid), 64'd1);
    chk("single_data",  bus_a.out_data, 64'hA5);
    chk("single_sel",   64'(bus_a.out_sel), 64'd2);
    chk("idle_ready",   64'(bus_a.in_ready), 64'd0);
    tick();
    @(negedge clk);
    chk("drain_valid", 64'(bus_a.out_valid), 64'd0);
    chk("drain_data",  bus_a.out_data, 64'hA5);
    chk("drain_sel",   64'(bus_a.out_sel), 64'd2);

    // re-home pointer, then all channels requesting with out_ready high
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) bus_a.in_data[i*64 +: 64] = 64'(100 + i);
    bus_a.in_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      er = RR ? 4'(1 << (k % 4)) : 4'b0001;
      chk("fair_ready", 64'(bus_a.in_ready), 64'(er));
      if (k > 0) begin
        es = RR ? (k - 1) % 4 : 0;
        chk("fair_sel",  64'(bus_a.out_sel), 64'(es));
        chk("fair_data", bus_a.out_data, 64'(100 + es));
      end
      tick();
    end
    bus_a.in_valid = 4'b0000;
    @(negedge clk);
    hold = RR ? 1 : 0;
    chk("fair_last_sel", 64'(bus_a.out_sel), 64'(hold));

    // backpressure: word held for 3 cycles with every channel requesting
    bus_a.out_ready = 1'b0;
    bus_a.in_valid  = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      chk("bp_ready", 64'(bus_a.in_ready), 64'd0);
      chk("bp_valid", 64'(bus_a.out_valid), 64'd1);
      chk("bp_sel",   64'(bus_a.out_sel), 64'(hold));
      chk("bp_data",  bus_a.out_data, 64'(100 + hold));
    end
    bus_a.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(bus_a.in_ready), RR ? 64'b0100 : 64'b0001);
    tick();
    bus_a.in_valid = 4'b0000;
    @(negedge clk);
    es = RR ? 2 : 0;
    chk("refill_valid", 64'(bus_a.out_valid), 64'd1);
    chk("refill_sel",   64'(bus_a.out_sel), 64'(es));
    chk("refill_data",  bus_a.out_data, 64'(100 + es));

    // reset while a word is held: it must vanish and the pointer re-home
    bus_a.out_ready = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 64'(bus_a.out_valid), 64'd0);
    bus_a.in_valid  = 4'b1111;
    bus_a.out_ready = 1'b1;
    #1;
    chk("mid_rst_ready", 64'(bus_a.in_ready), 64'b0001);
    tick();
    bus_a.in_valid = 4'b0000;
    @(negedge clk);
    chk("mid_rst_sel",  64'(bus_a.out_sel), 64'd0);
    chk("mid_rst_data", bus_a.out_data, 64'd100);

    // N=3 wrap: grant ch2, then 3'b011 twice
    for (int i = 0; i < 3; i++) bus_b.in_data[i*64 +: 64] = 64'(200 + i);
    bus_b.out_ready = 1'b1;
    bus_b.in_valid  = 3'b100;
    @(negedge clk);
    chk("n3_ready0", 64'(bus_b.in_ready), 64'b100);
    tick();
    bus_b.in_valid = 3'b011;
    @(negedge clk);
    chk("n3_sel0",   64'(bus_b.out_sel), 64'd2);
    chk("n3_ready1", 64'(bus_b.in_ready), 64'b001);
    tick();
    @(negedge clk);
    chk("n3_sel1",   64'(bus_b.out_sel), 64'd0);
    chk("n3_ready2", 64'(bus_b.in_ready), RR ? 64'b010 : 64'b001);
    tick();
    bus_b.in_valid = 3'b000;
    @(negedge clk);
    es = RR ? 1 : 0;
    chk("n3_sel2",  64'(bus_b.out_sel), 64'(es));
    chk("n3_data2", bus_b.out_data, 64'(200 + es));

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/muxn_arb.md
# muxn_arb

Parametrised N-input, registered, handshaked selector for the RISC-V datapath. It extends the 2:1 `mux2` to N channels with valid/ready flow control, round-robin or fixed-priority arbitration, and one output register stage. Typical use: merging writeback/forwarding sources or memory-request ports onto a single consumer.

## Interface
Parameters:
- WIDTH, 64, data width per channel
- N, 4, number of input channels (N >= 2)
- SELW, $clog2(N), width of the channel index (derived; not overridden)

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  N  per-channel request; bit i belongs to channel i
- in_ready  out  N  per-channel accept; at most one bit high per cycle
- in_data  in  N*WIDTH  flattened data; channel i occupies bits [i*WIDTH +: WIDTH]
- out_valid  out  1  output register holds a word
- out_ready  in  1  consumer accepts the word this cycle
- out_data  out  WIDTH  registered selected data
- out_sel  out  SELW  index of the channel that supplied out_data

## Operation
- Reset: clk and reset are fixed as above; reset is synchronous and active-high.
- Transfers:
  - An input transfer occurs on channel i when in_valid[i] && in_ready[i].
  - An output transfer occurs when out_valid && out_ready.
- Load enable: load = !out_valid || out_ready. The single output register can be refilled in the same cycle it drains.
- Grant:
  - When load=1 and any in_valid bit is set, exactly one channel g is granted and in_ready[g]=1.
  - All other in_ready bits are 0. When load=0, all in_ready bits are 0.
  - in_ready depends combinationally on in_valid and out_ready. Upstream must not make in_valid depend on in_ready.
- On an input transfer:
  - out_data <= in_data[g].
  - out_sel <= g.
  - out_valid <= 1.
- On an output transfer with no input transfer, out_valid <= 0. out_data and out_sel keep their last value.
- Round-robin pointer ptr (SELW bits):
  - The grant is the first valid channel found searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - On an input transfer, ptr <= (g == N-1) ? 0 : g+1. Wrap-around is explicit, so non-power-of-2 N is legal.
  - ptr is unchanged when no transfer occurs.
- Stall: while out_valid && !out_ready, out_data and out_sel stay stable and no input is accepted.

## Timing
- Reset values: out_valid=0, out_data=0, out_sel=0, ptr=0, in_ready=all 0 during reset.
- Latency: an input transfer in cycle t gives out_valid=1 with the data in cycle t+1.
- Throughput: one word per cycle when out_ready is held high.
- Simultaneous drain and fill in one cycle: out_valid stays 1 and the new word replaces the old.
- Reset mid-operation: any held word is discarded without being presented, and ptr returns to 0.
- Full/empty:
  - Empty: out_valid=0, so load=1 unconditionally.
  - Full: out_valid=1 && !out_ready, so every in_ready is 0.
- All in_valid=0: no grant and no state change, apart from draining the output.

## Configuration
- MUXN_ARB_RR_EN defined: round-robin arbitration as described, with ptr state.
- MUXN_ARB_RR_EN undefined:
  - Fixed priority; the lowest-index valid channel always wins.
  - ptr and its logic are removed.
  - All other behaviour, latency and reset values are identical.

## Test plan
- Reset then single source:
  - reset=1 for 2 cycles gives out_valid=0, out_data=0, out_sel=0.
  - Then in_valid=4'b0100, in_data ch2=64'hA5, out_ready=1 gives in_ready=4'b0100, and next cycle out_valid=1, out_data=64'hA5, out_sel=2.
- Round-robin fairness (RR_EN, N=4):
  - All four in_valid held high with out_ready=1 gives out_sel sequence 0,1,2,3,0,1 on consecutive cycles.
  - Each channel gets exactly one in_ready per 4 cycles.
- Fixed priority (no RR_EN): all in_valid high for 6 cycles gives out_sel=0 every cycle, and in_ready[3:1] stays 0.
- Backpressure:
  - A word is held with out_ready=0 for 3 cycles while in_valid=4'b1111. Expect all in_ready=0, and out_data/out_sel unchanged.
  - Raising out_ready gives a transfer plus a same-cycle refill, and out_valid never drops.
- Wrap with N=3, RR_EN:
  - After a grant to ch2, ptr returns to 0.
  - in_valid=3'b011 then grants ch0, then ch1.
- Reset mid-stream: assert reset while out_valid=1 and out_ready=0. Next cycle out_valid=0, ptr=0, and the held word is never transferred.
